// File: rtl/memoredf_pkg.sv
// Shared types for the decoupled demux path: buffer state and id width.
// The packet struct lives in each user, sized by its own localparams.
package memoredf_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } buf_state_e;

   // Index width for n destinations; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/decoupled_skid_buffer.sv
// Two-entry skid buffer; ready and valid are both driven from flops.
// Ports: aclk/aresetn, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module decoupled_skid_buffer
   import memoredf_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_e   state_q;
   buf_state_e   state_d;
   logic         ready_q;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         in_fire;
   logic         out_fire;
   logic         load_in;
   logic         load_skid;
   logic         pop_skid;

   assign in_ready  = ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign in_fire   = in_valid & ready_q;
   assign out_fire  = out_valid & out_ready;

   // ready is its own flop so it can be held low through reset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= EMPTY;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != TWO);
      end
   end

   always_comb begin
      state_d   = state_q;
      load_in   = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               load_in = 1'b1;
               state_d = ONE;
            end
         end
         ONE: begin
            if (out_fire && in_fire) begin
               load_in = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_d   = TWO;
            end
         end
         TWO: begin
            if (out_fire) begin
               pop_skid = 1'b1;
               state_d  = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // data path carries no reset
   always_ff @(posedge aclk) begin
      if (load_in) begin
         main_q <= in_data;
      end else if (pop_skid) begin
         main_q <= skid_q;
      end
      if (load_skid) begin
         skid_q <= in_data;
      end
   end

endmodule

// File: rtl/decoupled_io_demux.sv
// Routes one scheduled valid/ready stream to NUMBER_OF_QUEUES one-hot outputs.
// Ports: aclk, aresetn, in_valid/in_ready/in_id/in_packet,
// queues_valid/queues_ready/queues_packet; with DECOUPLED_IO_DEMUX_STATS_EN
// also stat_delivered[NUMBER_OF_QUEUES] and stat_dropped (saturating).
module decoupled_io_demux
   import memoredf_pkg::*;
#(
   parameter int DATA_SIZE        = 512,
   parameter int NUMBER_OF_QUEUES = 4,
   parameter int STAT_W           = 32,
   localparam int ID_W            = id_width(NUMBER_OF_QUEUES)
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ID_W-1:0]             in_id,
   input  logic [DATA_SIZE-1:0]        in_packet,
   output logic [NUMBER_OF_QUEUES-1:0] queues_valid,
   input  logic [NUMBER_OF_QUEUES-1:0] queues_ready,
`ifdef DECOUPLED_IO_DEMUX_STATS_EN
   output logic [STAT_W-1:0]           stat_delivered [NUMBER_OF_QUEUES],
   output logic [STAT_W-1:0]           stat_dropped,
`endif
   output logic [DATA_SIZE-1:0]        queues_packet
);

   localparam logic [ID_W:0] NQ = (ID_W+1)'(NUMBER_OF_QUEUES);

   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [DATA_SIZE-1:0] packet;
   } pkt_t;

   pkt_t in_pkt;
   pkt_t head;
   logic in_range;
   logic head_valid;
   logic out_fire;

   assign in_pkt   = '{id: in_id, packet: in_packet};
   assign in_range = ({1'b0, in_id} < NQ);

   // Out-of-range ids are consumed upstream but never enter the buffer.
   decoupled_skid_buffer #(
      .W($bits(pkt_t))
   ) u_buf (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_valid  (in_valid & in_range),
      .in_ready  (in_ready),
      .in_data   (in_pkt),
      .out_valid (head_valid),
      .out_ready (out_fire),
      .out_data  (head)
   );

   always_comb begin
      queues_valid = '0;
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
         queues_valid[i] = head_valid && (head.id == ID_W'(i));
      end
   end

   // only the selected queue's ready can complete a transfer
   assign out_fire      = |(queues_valid & queues_ready);
   assign queues_packet = head.packet;

`ifdef DECOUPLED_IO_DEMUX_STATS_EN
   logic drop;

   assign drop = in_valid & in_ready & ~in_range;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            stat_delivered[i] <= '0;
         end
         stat_dropped <= '0;
      end else begin
         for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (queues_valid[i] && queues_ready[i]
                && (stat_delivered[i] != '1)) begin
               stat_delivered[i] <= stat_delivered[i] + 1'b1;
            end
         end
         if (drop && (stat_dropped != '1)) begin
            stat_dropped <= stat_dropped + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_decoupled_io_demux.sv
// Directed bench for decoupled_io_demux with an in-order scoreboard.
// A 3-queue instance covers the out-of-range drop path.
module tb_decoupled_io_demux;

   localparam int DW = 16;

   typedef struct packed {
      logic [1:0]    id;
      logic [DW-1:0] pkt;
   } exp_t;

   logic          aclk;
   logic          aresetn;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_id;
   logic [DW-1:0] in_packet;
   logic [3:0]    qv;
   logic [3:0]    qr;
   logic [DW-1:0] qp;

   logic          in_valid3;
   logic          in_ready3;
   logic [1:0]    in_id3;
   logic [DW-1:0] in_packet3;
   logic [2:0]    qv3;
   logic [2:0]    qr3;
   logic [DW-1:0] qp3;

`ifdef DECOUPLED_IO_DEMUX_STATS_EN
   logic [31:0] sdel [4];
   logic [31:0] sdrop;
   logic [31:0] sdel3 [3];
   logic [31:0] sdrop3;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   decoupled_io_demux #(
      .DATA_SIZE(DW),
      .NUMBER_OF_QUEUES(4)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_id         (in_id),
      .in_packet     (in_packet),
      .queues_valid  (qv),
      .queues_ready  (qr),
`ifdef DECOUPLED_IO_DEMUX_STATS_EN
      .stat_delivered(sdel),
      .stat_dropped  (sdrop),
`endif
      .queues_packet (qp)
   );

   decoupled_io_demux #(
      .DATA_SIZE(DW),
      .NUMBER_OF_QUEUES(3)
   ) dut3 (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .in_valid      (in_valid3),
      .in_ready      (in_ready3),
      .in_id         (in_id3),
      .in_packet     (in_packet3),
      .queues_valid  (qv3),
      .queues_ready  (qr3),
`ifdef DECOUPLED_IO_DEMUX_STATS_EN
      .stat_delivered(sdel3),
      .stat_dropped  (sdrop3),
`endif
      .queues_packet (qp3)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [1:0] id, input logic [DW-1:0] p);
      in_valid  = 1'b1;
      in_id     = id;
      in_packet = p;
   endtask

   // scoreboard: push on accept, pop on delivery, in strict order
   always @(negedge aclk) begin
      if (!aresetn) begin
         sb.delete();
      end else begin
         if (qv != 4'b0) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_out", 64'(qv), 64'h0);
            end else begin
               chk("sb_valid", 64'(qv), 64'(4'b1 << sb[0].id));
               chk("sb_packet", 64'(qp), 64'(sb[0].pkt));
               if (|(qv & qr)) begin
                  void'(sb.pop_front());
               end
            end
         end else begin
            chk("sb_idle", 64'(sb.size()), 64'h0);
         end
         if (in_valid && in_ready) begin
            sb.push_back('{id: in_id, pkt: in_packet});
         end
      end
   end

   initial begin
      aresetn    = 1'b0;
      in_valid   = 1'b1;
      in_id      = 2'd0;
      in_packet  = 16'h0055;
      qr         = 4'b1111;
      in_valid3  = 1'b0;
      in_id3     = 2'd0;
      in_packet3 = '0;
      qr3        = 3'b111;

      // reset held with traffic offered
      repeat (3) begin
         tick();
         chk("rst_in_ready", 64'(in_ready), 64'h0);
         chk("rst_qv", 64'(qv), 64'h0);
      end
      aresetn  = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("post_rst_ready", 64'(in_ready), 64'h1);
      chk("post_rst_qv", 64'(qv), 64'h0);
      tick();
      chk("post_rst_idle", 64'(qv), 64'h0);

      // streaming, one per cycle
      for (int k = 0; k < 4; k++) begin
         send(2'(k), 16'hA0 + 16'(k));
         tick();
         chk("stream_qv", 64'(qv), 64'(4'b1 << k));
         chk("stream_pkt", 64'(qp), 64'(16'hA0 + 16'(k)));
         chk("stream_ready", 64'(in_ready), 64'h1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", 64'(qv), 64'h0);

      // backpressure on queue 2
      qr = 4'b1011;
      send(2'd2, 16'hB0);
      tick();
      chk("bp_qv0", 64'(qv), 64'h4);
      chk("bp_ready0", 64'(in_ready), 64'h1);
      send(2'd0, 16'hB1);
      tick();
      chk("bp_ready_full", 64'(in_ready), 64'h0);
      chk("bp_qv1", 64'(qv), 64'h4);
      chk("bp_pkt1", 64'(qp), 64'hB0);
      send(2'd1, 16'hB2);
      tick();
      chk("bp_wait_ready", 64'(in_ready), 64'h0);
      chk("bp_hold_pkt", 64'(qp), 64'hB0);

      // other queues' ready bits must not matter
      qr = 4'b0001;
      tick();
      chk("ign_qv_a", 64'(qv), 64'h4);
      chk("ign_pkt_a", 64'(qp), 64'hB0);
      qr = 4'b1000;
      tick();
      chk("ign_qv_b", 64'(qv), 64'h4);
      chk("ign_pkt_b", 64'(qp), 64'hB0);
      chk("ign_ready", 64'(in_ready), 64'h0);

      qr = 4'b1111;
      tick();
      chk("rel_qv1", 64'(qv), 64'h1);
      chk("rel_pkt1", 64'(qp), 64'hB1);
      chk("rel_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      chk("rel_qv2", 64'(qv), 64'h2);
      chk("rel_pkt2", 64'(qp), 64'hB2);
      tick();
      chk("rel_drain", 64'(qv), 64'h0);

`ifdef DECOUPLED_IO_DEMUX_STATS_EN
      chk("stat_q0", 64'(sdel[0]), 64'd2);
      chk("stat_q1", 64'(sdel[1]), 64'd2);
      chk("stat_q2", 64'(sdel[2]), 64'd2);
      chk("stat_q3", 64'(sdel[3]), 64'd1);
      chk("stat_drop", 64'(sdrop), 64'd0);
`endif

      // fill to TWO, then reset mid-operation
      qr = 4'b0000;
      send(2'd0, 16'hC0);
      tick();
      send(2'd3, 16'hC1);
      tick();
      chk("mid_full", 64'(in_ready), 64'h0);
      aresetn  = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("mid_rst_qv", 64'(qv), 64'h0);
      chk("mid_rst_ready", 64'(in_ready), 64'h0);
`ifdef DECOUPLED_IO_DEMUX_STATS_EN
      chk("mid_rst_stat_q0", 64'(sdel[0]), 64'd0);
      chk("mid_rst_stat_q2", 64'(sdel[2]), 64'd0);
`endif
      aresetn = 1'b1;
      qr      = 4'b1111;
      tick();
      chk("mid_post_qv", 64'(qv), 64'h0);
      chk("mid_post_ready", 64'(in_ready), 64'h1);
      tick();
      chk("mid_post_idle", 64'(qv), 64'h0);

      // out-of-range id on the 3-queue instance
      in_valid3  = 1'b1;
      in_id3     = 2'd3;
      in_packet3 = 16'hCC;
      tick();
      chk("oor_ready", 64'(in_ready3), 64'h1);
      chk("oor_qv", 64'(qv3), 64'h0);
      in_id3     = 2'd1;
      in_packet3 = 16'hCD;
      tick();
      in_valid3 = 1'b0;
      chk("oor_next_qv", 64'(qv3), 64'h2);
      chk("oor_next_pkt", 64'(qp3), 64'hCD);
      tick();
      chk("oor_drain", 64'(qv3), 64'h0);
`ifdef DECOUPLED_IO_DEMUX_STATS_EN
      chk("oor_stat_drop", 64'(sdrop3), 64'd1);
      chk("oor_stat_q1", 64'(sdel3[1]), 64'd1);
      chk("oor_stat_q0", 64'(sdel3[0]), 64'd0);
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
